// File: rtl/xbar_pkg.sv
// Shared interconnect definitions: master/slave indices, arbiter state
// encoding and the one-hot to index helper.
package xbar_pkg;

    localparam int unsigned CPU_MASTER   = 0;

    localparam int unsigned SLV_MEMORY   = 0;
    localparam int unsigned SLV_GPU_CTRL = 1;
    localparam int unsigned SLV_SYS_REGS = 2;
    localparam int unsigned SLV_DEBUG    = 3;
    localparam int unsigned NUM_SLAVES   = 4;

    typedef enum logic [0:0] {ARB_IDLE, ARB_BUSY} arb_state_e;

    // Index of the set bit; 0 for an all-zero vector (callers zero-extend to 32 bits).
    function automatic int unsigned onehot2idx(input logic [31:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (onehot[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/xbar_slave_arbiter_if.sv
// Request/grant bundle between the masters' address decoders and one
// slave-port arbiter.
interface xbar_slave_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 9,
    parameter int unsigned ID_W        = 4
);
    logic [NUM_MASTERS-1:0] req;
    logic                   slave_ack;
    logic [NUM_MASTERS-1:0] grant;
    logic [ID_W-1:0]        granted_id;
    logic                   any_grant;
    logic                   timeout_err;
    logic                   cpu_boosted;

    modport master (
        output req, slave_ack,
        input  grant, granted_id, any_grant, timeout_err, cpu_boosted
    );

    modport slave (
        input  req, slave_ack,
        output grant, granted_id, any_grant, timeout_err, cpu_boosted
    );
endinterface

// File: rtl/gpu_rr_picker.sv
// Combinational round-robin picker over the GPU requesters (indices 1..N-1),
// searching from the entry after rr_ptr and wrapping back to index 1.
module gpu_rr_picker #(
    parameter int unsigned NUM_MASTERS = 9,
    parameter int unsigned ID_W        = 4
) (
    input  logic [NUM_MASTERS-1:1] req,
    input  logic [ID_W-1:0]        rr_ptr,
    input  logic [NUM_MASTERS-1:1] mask,
    output logic [NUM_MASTERS-1:1] pick,
    output logic                   pick_valid
);

    logic [NUM_MASTERS-1:1] cand;

    assign cand = req & ~mask;

    // First pass covers rr_ptr+1..N-1, second pass the wrapped range 1..rr_ptr.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int unsigned i = 1; i < NUM_MASTERS; i++) begin
            if (!pick_valid && cand[i] && (i > 32'(rr_ptr))) begin
                pick[i]    = 1'b1;
                pick_valid = 1'b1;
            end
        end
        for (int unsigned i = 1; i < NUM_MASTERS; i++) begin
            if (!pick_valid && cand[i] && (i <= 32'(rr_ptr))) begin
                pick[i]    = 1'b1;
                pick_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// Per-slave arbiter: locked grant until ack/abort/watchdog, round-robin GPUs,
// lowest-priority CPU with an aging override.
module xbar_slave_arbiter
    import xbar_pkg::*;
#(
    parameter int unsigned NUM_MASTERS  = 9,
    parameter int unsigned ID_W         = 4,
    parameter int unsigned STARVE_LIMIT = 16,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    xbar_slave_arbiter_if.slave  bus
);

    localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    arb_state_e             state;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [ID_W-1:0]        id_q;
    logic                   any_q;
    logic                   timeout_q;
    logic                   boosted_q;
    logic [ID_W-1:0]        rr_ptr;
    logic [AGE_W-1:0]       age;
    logic [AGE_W-1:0]       age_nxt;
    logic [WD_W-1:0]        wd_cnt;

    logic [NUM_MASTERS-1:1] gpu_pick;
    logic                   gpu_valid;
    logic                   release_c;
    logic                   timeout_c;
    logic                   arbitrate_c;
    logic                   cpu_win_c;
    logic                   gpu_win_c;
    logic [NUM_MASTERS-1:0] grant_nxt;

    assign bus.grant       = grant_q;
    assign bus.granted_id  = id_q;
    assign bus.any_grant   = any_q;
    assign bus.timeout_err = timeout_q;
    assign bus.cpu_boosted = boosted_q;

    // The current grant doubles as the re-arbitration mask (zero while idle).
    gpu_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .ID_W        (ID_W)
    ) u_picker (
        .req        (bus.req[NUM_MASTERS-1:1]),
        .rr_ptr     (rr_ptr),
        .mask       (grant_q[NUM_MASTERS-1:1]),
        .pick       (gpu_pick),
        .pick_valid (gpu_valid)
    );

    // Release causes while busy: ack beats abort beats watchdog.
    always_comb begin
        release_c = 1'b0;
        timeout_c = 1'b0;
        if (state == ARB_BUSY) begin
            if (bus.slave_ack) begin
                release_c = 1'b1;
            end else if ((bus.req & grant_q) == '0) begin
                release_c = 1'b1;
            end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                release_c = 1'b1;
                timeout_c = 1'b1;
            end
        end
    end

    // CPU wins only when boosted or when no GPU is requesting at all.
    assign arbitrate_c = (state == ARB_IDLE) || release_c;
    assign cpu_win_c   = bus.req[CPU_MASTER] && !grant_q[CPU_MASTER] &&
                         (boosted_q || (bus.req[NUM_MASTERS-1:1] == '0));
    assign gpu_win_c   = !cpu_win_c && gpu_valid;
    assign grant_nxt   = cpu_win_c ? {{(NUM_MASTERS-1){1'b0}}, 1'b1} :
                         gpu_win_c ? {gpu_pick, 1'b0} : '0;

    always_comb begin
        age_nxt = age;
        if (!bus.req[CPU_MASTER] || grant_q[CPU_MASTER]) begin
            age_nxt = '0;
        end else if (age != AGE_W'(STARVE_LIMIT)) begin
            age_nxt = age + AGE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            any_q     <= 1'b0;
            timeout_q <= 1'b0;
            boosted_q <= 1'b0;
            rr_ptr    <= ID_W'(NUM_MASTERS - 1);
            age       <= '0;
            wd_cnt    <= '0;
        end else begin
            timeout_q <= timeout_c;
            age       <= age_nxt;
            boosted_q <= (age_nxt == AGE_W'(STARVE_LIMIT));
            if (arbitrate_c) begin
                grant_q <= grant_nxt;
                id_q    <= ID_W'(onehot2idx(32'(grant_nxt)));
                any_q   <= |grant_nxt;
                wd_cnt  <= '0;
                state   <= (|grant_nxt) ? ARB_BUSY : ARB_IDLE;
                if (gpu_win_c) begin
                    rr_ptr <= ID_W'(onehot2idx(32'({gpu_pick, 1'b0})));
                end
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Directed bench for xbar_slave_arbiter: expected grant ids are queued by the
// stimulus and popped by a monitor on every new grant.
module tb_xbar_slave_arbiter;

    logic clk;
    logic rst;

    xbar_slave_arbiter_if #(.NUM_MASTERS(9), .ID_W(4)) bus ();

    xbar_slave_arbiter #(
        .NUM_MASTERS  (9),
        .ID_W         (4),
        .STARVE_LIMIT (4),
        .TIMEOUT      (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    logic mon_en = 1'b0;
    logic prev_any;
    int   prev_id;
    int   pulses;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_idx(input logic [8:0] g);
        int r;
        r = 0;
        for (int i = 0; i < 9; i++) if (g[i]) r = i;
        return r;
    endfunction

    // Drive one cycle of inputs; returns after the sampling edge, away from it.
    task automatic cyc(input logic [8:0] r, input logic a);
        bus.req       = r;
        bus.slave_ack = a;
        @(negedge clk);
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each new grant.
    always @(negedge clk) begin
        if (mon_en) begin
            check("onehot", int'($countones(bus.grant) <= 1), 1);
            check("any_grant_vs_grant", int'(bus.any_grant), int'(|bus.grant));
            check("granted_id_map", int'(bus.granted_id), ref_idx(bus.grant));
            if (bus.any_grant && (!prev_any || int'(bus.granted_id) != prev_id)) begin
                if (exp_q.size() == 0) check("unexpected_grant", int'(bus.granted_id), -1);
                else                   check("grant_id", int'(bus.granted_id), exp_q.pop_front());
            end
            prev_any = bus.any_grant;
            prev_id  = int'(bus.granted_id);
        end
    end

    initial begin
        rst           = 1'b1;
        bus.req       = '0;
        bus.slave_ack = 1'b0;
        prev_any      = 1'b0;
        prev_id       = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_grant", int'(bus.grant), 0);
        check("rst_id", int'(bus.granted_id), 0);
        check("rst_any", int'(bus.any_grant), 0);
        check("rst_timeout", int'(bus.timeout_err), 0);
        check("rst_boost", int'(bus.cpu_boosted), 0);
        mon_en = 1'b1;
        rst    = 1'b0;
        cyc(9'h000, 1'b0);

        // T1 basic grant, hold, ack
        exp_q.push_back(2);
        cyc(9'h004, 1'b0);
        cyc(9'h004, 1'b0);
        check("t1_held", int'(bus.granted_id), 2);
        cyc(9'h004, 1'b1);
        check("t1_release", int'(bus.any_grant), 0);
        cyc(9'h000, 1'b1);
        check("t1_ack_idle_ignored", int'(bus.any_grant), 0);

        // T2 round-robin with zero bubbles
        rst = 1'b1; cyc(9'h000, 1'b0); rst = 1'b0;
        for (int i = 1; i <= 8; i++) exp_q.push_back(i);
        exp_q.push_back(1);
        for (int i = 0; i < 9; i++) begin
            cyc(9'h1FE, 1'b1);
            check("t2_no_gap", int'(bus.any_grant), 1);
        end
        cyc(9'h000, 1'b1);
        check("t2_idle", int'(bus.any_grant), 0);

        // T3 CPU aging (limit 4)
        rst = 1'b1; cyc(9'h000, 1'b0); rst = 1'b0;
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
        cyc(9'h003, 1'b1);
        cyc(9'h003, 1'b1);
        check("t3_masked_idle", int'(bus.any_grant), 0);
        cyc(9'h003, 1'b1);
        check("t3_boost_pre", int'(bus.cpu_boosted), 0);
        cyc(9'h003, 1'b1);
        check("t3_boost_set", int'(bus.cpu_boosted), 1);
        cyc(9'h003, 1'b1);
        check("t3_cpu_granted", int'(bus.grant), 1);
        check("t3_boost_hold", int'(bus.cpu_boosted), 1);
        cyc(9'h003, 1'b1);
        check("t3_boost_clear", int'(bus.cpu_boosted), 0);
        cyc(9'h000, 1'b1);

        // T4 watchdog (timeout 8)
        rst = 1'b1; cyc(9'h000, 1'b0); rst = 1'b0;
        exp_q.push_back(4); exp_q.push_back(5);
        pulses = 0;
        cyc(9'h030, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cyc(9'h030, 1'b0);
            pulses += int'(bus.timeout_err);
        end
        check("t4_still_held", int'(bus.granted_id), 4);
        cyc(9'h030, 1'b0);
        pulses += int'(bus.timeout_err);
        check("t4_timeout_pulse", int'(bus.timeout_err), 1);
        check("t4_next_grant", int'(bus.granted_id), 5);
        cyc(9'h030, 1'b0);
        pulses += int'(bus.timeout_err);
        check("t4_pulse_end", int'(bus.timeout_err), 0);
        check("t4_pulse_count", pulses, 1);
        cyc(9'h000, 1'b0);

        // T5 abort, then ack racing the watchdog
        exp_q.push_back(6); exp_q.push_back(7);
        cyc(9'h040, 1'b0);
        cyc(9'h040, 1'b0);
        cyc(9'h000, 1'b0);
        check("t5_abort", int'(bus.any_grant), 0);
        cyc(9'h080, 1'b0);
        for (int i = 0; i < 7; i++) cyc(9'h080, 1'b0);
        cyc(9'h080, 1'b1);
        check("t5_race_no_err", int'(bus.timeout_err), 0);
        check("t5_race_release", int'(bus.any_grant), 0);
        cyc(9'h000, 1'b0);
        check("t5_race_no_err_late", int'(bus.timeout_err), 0);

        // T6 reset while busy
        exp_q.push_back(5); exp_q.push_back(1);
        cyc(9'h020, 1'b0);
        cyc(9'h020, 1'b0);
        rst = 1'b1;
        cyc(9'h1FE, 1'b0);
        check("t6_rst_grant", int'(bus.grant), 0);
        check("t6_rst_id", int'(bus.granted_id), 0);
        check("t6_rst_any", int'(bus.any_grant), 0);
        rst = 1'b0;
        cyc(9'h1FE, 1'b0);
        check("t6_first_after_rst", int'(bus.granted_id), 1);
        cyc(9'h000, 1'b0);
        cyc(9'h000, 1'b0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
